keypad_emulator: RTL and testbench

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_emulator.sv | 161 ++++++++++++++++
 tb/tb_keypad_emulator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// Matrix keypad key model: turns a press request into a bounced contact closure
// on the selected row/column crossing, as seen by a column-scanning controller.
module keypad_emulator #(
  parameter int BOUNCE_CYCLES  = 8,
  parameter int BOUNCE_PERIOD  = 2,
  parameter int HOLD_CYCLES    = 1000,
  parameter int RELEASE_CYCLES = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] column,
  output logic [3:0] row,
  input  logic [3:0] key_code,
  input  logic       press_valid,
  output logic       press_ready,
  output logic       busy,
  output logic [7:0] press_count
);

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_IN,
    HOLD,
    BOUNCE_OUT,
    GAP
  } state_t;

  localparam bit        HAS_BOUNCE  = (BOUNCE_CYCLES > 0);
  localparam logic [15:0] BOUNCE_LAST = 16'(BOUNCE_CYCLES - 1);
  localparam logic [15:0] TICK_LAST   = 16'(BOUNCE_PERIOD - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GAP_LAST    = 16'(RELEASE_CYCLES - 1);

  state_t      r_state;
  logic [15:0] r_phaseCnt;
  logic [15:0] r_tickCnt;
  logic        r_contact;
  logic [3:0]  r_key;
  logic [7:0]  r_pressCount;

  state_t      w_stateNext;
  logic [15:0] w_phaseNext;
  logic [15:0] w_tickNext;
  logic        w_contactNext;
  logic [3:0]  w_keyNext;
  logic [7:0]  w_countNext;

  logic [1:0]  w_keyRow;
  logic [1:0]  w_keyCol;
  logic        w_colDriven;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_phaseCnt   <= '0;
      r_tickCnt    <= '0;
      r_contact    <= 1'b0;
      r_key        <= '0;
      r_pressCount <= '0;
    end else begin
      r_state      <= w_stateNext;
      r_phaseCnt   <= w_phaseNext;
      r_tickCnt    <= w_tickNext;
      r_contact    <= w_contactNext;
      r_key        <= w_keyNext;
      r_pressCount <= w_countNext;
    end
  end

  // The tick counter paces contact toggles inside a bounce phase; the phase
  // counter measures the length of whichever phase is active.
  always_comb begin
    w_stateNext   = r_state;
    w_phaseNext   = r_phaseCnt + 16'd1;
    w_tickNext    = r_tickCnt + 16'd1;
    w_contactNext = r_contact;
    w_keyNext     = r_key;
    w_countNext   = r_pressCount;

    case (r_state)
      IDLE: begin
        w_phaseNext   = '0;
        w_tickNext    = '0;
        w_contactNext = 1'b0;
        if (press_valid) begin
          w_keyNext     = key_code;
          w_contactNext = 1'b1;
          w_stateNext   = HAS_BOUNCE ? BOUNCE_IN : HOLD;
        end
      end

      BOUNCE_IN: begin
        if (r_phaseCnt == BOUNCE_LAST) begin
          w_stateNext   = HOLD;
          w_phaseNext   = '0;
          w_tickNext    = '0;
          w_contactNext = 1'b1;
        end else if (r_tickCnt == TICK_LAST) begin
          w_tickNext    = '0;
          w_contactNext = ~r_contact;
        end
      end

      HOLD: begin
        if (r_phaseCnt == HOLD_LAST) begin
          w_stateNext   = HAS_BOUNCE ? BOUNCE_OUT : GAP;
          w_phaseNext   = '0;
          w_tickNext    = '0;
          w_contactNext = 1'b0;
        end
      end

      BOUNCE_OUT: begin
        if (r_phaseCnt == BOUNCE_LAST) begin
          w_stateNext   = GAP;
          w_phaseNext   = '0;
          w_tickNext    = '0;
          w_contactNext = 1'b0;
        end else if (r_tickCnt == TICK_LAST) begin
          w_tickNext    = '0;
          w_contactNext = ~r_contact;
        end
      end

      GAP: begin
        if (r_phaseCnt == GAP_LAST) begin
          w_stateNext   = IDLE;
          w_phaseNext   = '0;
          w_tickNext    = '0;
          w_contactNext = 1'b0;
          w_countNext   = r_pressCount + 8'd1;
        end
      end

      default: begin
        w_stateNext   = IDLE;
        w_phaseNext   = '0;
        w_tickNext    = '0;
        w_contactNext = 1'b0;
      end
    endcase
  end

  assign w_keyRow    = r_key[3:2];
  assign w_keyCol    = r_key[1:0];
  assign w_colDriven = ~column[w_keyCol];

  // A closed contact shorts the latched row to its column, so the row only
  // goes low while that particular column is being driven.
  always_comb begin
    row = 4'b1111;
    if (r_contact && w_colDriven) begin
      row[w_keyRow] = 1'b0;
    end
  end

  assign press_ready = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign press_count = r_pressCount;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench: a default-parameter instance for bounce/hold/gap timing and a
// bounce-free short instance for the row mapping table and counter wrap.
module tb_keypad_emulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       dReset, dValid, dReady, dBusy;
  logic [3:0] dColumn, dRow, dKey;
  logic [7:0] dCount;

  logic       sReset, sValid, sReady, sBusy;
  logic [3:0] sColumn, sRow, sKey;
  logic [7:0] sCount;

  int checks   = 0;
  int failures = 0;
  int expDCount = 0;
  int sPresses  = 0;

  typedef struct {
    logic [3:0] key;
    logic [3:0] column;
    logic [3:0] expRow;
  } vec_t;

  vec_t vecs[10];

  keypad_emulator dut (
    .clk(clk), .reset(dReset), .column(dColumn), .row(dRow),
    .key_code(dKey), .press_valid(dValid), .press_ready(dReady),
    .busy(dBusy), .press_count(dCount)
  );

  keypad_emulator #(
    .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(1), .HOLD_CYCLES(4), .RELEASE_CYCLES(2)
  ) dutSmall (
    .clk(clk), .reset(sReset), .column(sColumn), .row(sRow),
    .key_code(sKey), .press_valid(sValid), .press_ready(sReady),
    .busy(sBusy), .press_count(sCount)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Contact level in clock i of a default-parameter press (8/2/1000/200).
  function automatic bit contactModel(int i);
    if (i < 8)         return ((i / 2) % 2) == 0;
    else if (i < 1008) return 1'b1;
    else if (i < 1016) return (((i - 1008) / 2) % 2) == 1;
    else               return 1'b0;
  endfunction

  // Called right after the accepting edge; latched key is 0110 (row 1, col 2).
  task automatic watchDefaultPress(input bit scan);
    for (int i = 0; i < 1216; i++) begin
      logic [3:0] col;
      logic [3:0] expRow;
      if (scan) begin
        case (i % 4)
          0:       col = 4'b1110;
          1:       col = 4'b1101;
          2:       col = 4'b1011;
          default: col = 4'b0111;
        endcase
        dColumn = col;
        #1;
      end else begin
        col = dColumn;
      end
      expRow = (contactModel(i) && col == 4'b1011) ? 4'b1101 : 4'b1111;
      checkOutput(scan ? "scanRow" : "pressRow", dRow, expRow);
      if (i == 0 || i == 1215) begin
        checkOutput("pressBusy", dBusy, 1);
        checkOutput("pressCountHeld", dCount, expDCount);
      end
      @(posedge clk); #1;
    end
    expDCount++;
    checkOutput("pressCountDone", dCount, expDCount % 256);
    checkOutput("pressIdleBusy", dBusy, 0);
    checkOutput("pressIdleReady", dReady, 1);
  endtask

  task automatic applyStimulus(input logic [3:0] key, input logic [3:0] col,
                               input logic [3:0] expRow, input bit checkRows);
    checkOutput("smallReadyBefore", sReady, 1);
    sKey = key; sColumn = col; sValid = 1'b1;
    @(posedge clk); #1;
    sValid = 1'b0;
    sKey = ~key;
    for (int i = 0; i < 4; i++) begin
      if (checkRows) checkOutput("smallHoldRow", sRow, expRow);
      @(posedge clk); #1;
    end
    if (checkRows) checkOutput("smallGapRow", sRow, 4'b1111);
    repeat (2) @(posedge clk);
    #1;
    sPresses++;
    checkOutput("smallCount", sCount, sPresses % 256);
    checkOutput("smallIdleBusy", sBusy, 0);
  endtask

  initial begin
    int lowCnt;

    vecs[0] = '{4'b0000, 4'b1110, 4'b1110};
    vecs[1] = '{4'b0110, 4'b1011, 4'b1101};
    vecs[2] = '{4'b1111, 4'b0111, 4'b0111};
    vecs[3] = '{4'b1001, 4'b0000, 4'b1011};
    vecs[4] = '{4'b1001, 4'b1101, 4'b1011};
    vecs[5] = '{4'b1001, 4'b1111, 4'b1111};
    vecs[6] = '{4'b0011, 4'b0111, 4'b1110};
    vecs[7] = '{4'b1110, 4'b1011, 4'b0111};
    vecs[8] = '{4'b1110, 4'b0100, 4'b1111};
    vecs[9] = '{4'b0100, 4'b1110, 4'b1101};

    dReset = 1'b0; dColumn = 4'b1111; dKey = 4'b0000; dValid = 1'b0;
    sReset = 1'b0; sColumn = 4'b1111; sKey = 4'b0000; sValid = 1'b0;
    #12;
    checkOutput("resetRow", dRow, 4'b1111);
    checkOutput("resetBusy", dBusy, 0);
    checkOutput("resetReady", dReady, 1);
    checkOutput("resetCount", dCount, 0);
    checkOutput("resetSmallRow", sRow, 4'b1111);
    checkOutput("resetSmallReady", sReady, 1);
    @(posedge clk); #1;
    dReset = 1'b1; sReset = 1'b1;

    // Abort a press in the middle of HOLD with an asynchronous reset.
    dKey = 4'b0110; dColumn = 4'b1011; dValid = 1'b1;
    @(posedge clk); #1;
    dValid = 1'b0;
    checkOutput("firstAcceptBusy", dBusy, 1);
    repeat (100) @(posedge clk);
    #1;
    checkOutput("holdRowBeforeReset", dRow, 4'b1101);
    dReset = 1'b0;
    #1;
    checkOutput("asyncResetRow", dRow, 4'b1111);
    checkOutput("asyncResetBusy", dBusy, 0);
    checkOutput("asyncResetReady", dReady, 1);
    checkOutput("asyncResetCount", dCount, expDCount);
    @(posedge clk); #1;
    dReset = 1'b1;

    // Full default press; key_code changes after acceptance must not matter.
    dKey = 4'b0110; dColumn = 4'b1011; dValid = 1'b1;
    @(posedge clk); #1;
    dValid = 1'b0;
    dKey = 4'b1001;
    watchDefaultPress(1'b0);

    // Same press with a one-hot-low column scan.
    dKey = 4'b0110; dValid = 1'b1;
    @(posedge clk); #1;
    dValid = 1'b0;
    watchDefaultPress(1'b1);

    // press_valid held high: one acceptance per sequence, nothing queued.
    dKey = 4'b0110; dColumn = 4'b1011; dValid = 1'b1;
    @(posedge clk); #1;
    lowCnt = 0;
    while (dReady == 1'b0 && lowCnt < 2000) begin
      lowCnt++;
      @(posedge clk); #1;
    end
    checkOutput("readyLowClocks", lowCnt, 1216);
    expDCount++;
    checkOutput("heldValidCount1", dCount, expDCount);
    @(posedge clk); #1;
    checkOutput("heldValidReaccept", dBusy, 1);
    dValid = 1'b0;
    repeat (1216) @(posedge clk);
    #1;
    expDCount++;
    checkOutput("heldValidCount2", dCount, expDCount);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("noQueuedBusy", dBusy, 0);
    checkOutput("noQueuedCount", dCount, expDCount);

    // Row mapping table on the bounce-free instance.
    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].key, vecs[v].column, vecs[v].expRow, 1'b1);
    end

    // A request raised while busy is dropped.
    sKey = 4'b0000; sColumn = 4'b1110; sValid = 1'b1;
    @(posedge clk); #1;
    sValid = 1'b0;
    @(posedge clk); #1;
    sValid = 1'b1;
    checkOutput("busyReadyLow", sReady, 0);
    @(posedge clk); #1;
    sValid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    sPresses++;
    checkOutput("ignoredValidCount", sCount, sPresses % 256);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ignoredValidIdle", sBusy, 0);
    checkOutput("ignoredValidCountStill", sCount, sPresses % 256);

    // Run the counter through its wrap.
    while (sPresses < 256) begin
      applyStimulus(4'b0101, 4'b1111, 4'b1111, 1'b0);
    end
    checkOutput("wrapCount", sCount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
